// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit.
// Accepts one operation per Start in IDLE, runs 32 shift-add (multiply) or
// restoring shift-subtract (divide) iterations, then pulses Done/RegWrite for
// one cycle with the sign-corrected Result and the captured WriteReg tag.
// Ports:
//   clock, reset_n        : clock, asynchronous active-low reset
//   Start, Funct3         : request (sampled in IDLE only), RV32M funct3
//   Data1, Data2, RdIn    : rs1/rs2 operands and destination tag
//   Busy, Done, RegWrite  : state != IDLE, one-cycle completion strobe (x2)
//   Result, WriteReg      : registered result and tag, held until next op
// Optional build macro MULDIV_EARLY_OUT_EN: divide-by-zero, signed overflow
// and multiply-by-zero skip CALC and complete one cycle after Start.
module muldiv_unit #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned REG_ADDR_W = 6
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  Start,
    input  logic [2:0]            Funct3,
    input  logic [XLEN-1:0]       Data1,
    input  logic [XLEN-1:0]       Data2,
    input  logic [REG_ADDR_W-1:0] RdIn,
    output logic                  Busy,
    output logic                  Done,
    output logic [XLEN-1:0]       Result,
    output logic [REG_ADDR_W-1:0] WriteReg,
    output logic                  RegWrite
);

    localparam int unsigned CNT_W = $clog2(XLEN);
    localparam int unsigned ACC_W = 2 * XLEN;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state_q, state_d;
    logic [2:0]         op_q;
    logic [XLEN-1:0]    opb_q;   // multiplicand or divisor magnitude
    logic [ACC_W-1:0]   acc_q;   // mul: {partial hi, multiplier}; div: {rem, quo}
    logic               neg_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               done_q;

    logic               a_signed_c, b_signed_c, a_neg_c, b_neg_c, neg_c;
    logic [XLEN-1:0]    a_mag_c, b_mag_c;
    logic               early_c;
    logic [XLEN-1:0]    early_res_c;
    logic [XLEN:0]      mul_sum_c;
    logic [XLEN:0]      div_trial_c;
    logic               div_ge_c;
    logic [XLEN-1:0]    div_rem_c;
    logic [ACC_W-1:0]   acc_nxt_c;
    logic [ACC_W-1:0]   prod_c;
    logic [XLEN-1:0]    res_c;
    logic               last_iter_c;

    // Operand magnitudes and result sign captured at Start
    always_comb begin
        a_signed_c = 1'b0;
        b_signed_c = 1'b0;
        case (Funct3)
            3'b000, 3'b001, 3'b100, 3'b110: begin
                a_signed_c = 1'b1;
                b_signed_c = 1'b1;
            end
            3'b010:  a_signed_c = 1'b1;
            default: ;
        endcase
        a_neg_c = a_signed_c & Data1[XLEN-1];
        b_neg_c = b_signed_c & Data2[XLEN-1];
        a_mag_c = a_neg_c ? -Data1 : Data1;
        b_mag_c = b_neg_c ? -Data2 : Data2;
        // Quotient sign ignores a zero divisor; remainder follows the dividend
        if (Funct3 == 3'b100)
            neg_c = (a_neg_c ^ b_neg_c) & (|Data2);
        else if (Funct3[2] & Funct3[1])
            neg_c = a_neg_c;
        else
            neg_c = a_neg_c ^ b_neg_c;
    end

`ifdef MULDIV_EARLY_OUT_EN
    // Special cases resolvable directly from the operands
    always_comb begin
        early_c     = 1'b0;
        early_res_c = '0;
        if (Funct3[2]) begin
            if (Data2 == '0) begin
                early_c     = 1'b1;
                early_res_c = Funct3[1] ? Data1 : '1;
            end else if (!Funct3[0] && (Data1 == {1'b1, {(XLEN-1){1'b0}}}) && (Data2 == '1)) begin
                early_c     = 1'b1;
                early_res_c = Funct3[1] ? '0 : Data1;
            end
        end else if ((Data1 == '0) || (Data2 == '0)) begin
            early_c = 1'b1;
        end
    end
`else
    assign early_c     = 1'b0;
    assign early_res_c = '0;
`endif

    // One iteration of shift-add multiply or restoring divide
    always_comb begin
        mul_sum_c   = {1'b0, acc_q[ACC_W-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        div_trial_c = acc_q[ACC_W-1:XLEN-1];
        div_ge_c    = (div_trial_c >= {1'b0, opb_q});
        div_rem_c   = div_ge_c ? XLEN'(div_trial_c - {1'b0, opb_q}) : div_trial_c[XLEN-1:0];
        if (op_q[2])
            acc_nxt_c = {div_rem_c, acc_q[XLEN-2:0], div_ge_c};
        else
            acc_nxt_c = {mul_sum_c, acc_q[XLEN-1:1]};
    end

    // Sign correction and result selection from the final iteration
    always_comb begin
        prod_c = neg_q ? -acc_nxt_c : acc_nxt_c;
        case (op_q)
            3'b000:         res_c = prod_c[XLEN-1:0];
            3'b100, 3'b101: res_c = neg_q ? -acc_nxt_c[XLEN-1:0] : acc_nxt_c[XLEN-1:0];
            3'b110, 3'b111: res_c = neg_q ? -acc_nxt_c[ACC_W-1:XLEN] : acc_nxt_c[ACC_W-1:XLEN];
            default:        res_c = prod_c[ACC_W-1:XLEN];
        endcase
    end

    assign last_iter_c = (cnt_q == CNT_W'(XLEN - 1));

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (Start) state_d = early_c ? DONE : CALC;
            CALC: if (last_iter_c) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, datapath and registered outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            op_q     <= '0;
            opb_q    <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            Busy     <= 1'b0;
            Result   <= '0;
            WriteReg <= '0;
        end else begin
            state_q <= state_d;
            Busy    <= (state_d != IDLE);
            done_q  <= (state_d == DONE);
            case (state_q)
                IDLE: if (Start) begin
                    op_q     <= Funct3;
                    opb_q    <= b_mag_c;
                    acc_q    <= {{XLEN{1'b0}}, a_mag_c};
                    neg_q    <= neg_c;
                    cnt_q    <= '0;
                    WriteReg <= RdIn;
                    if (early_c) Result <= early_res_c;
                end
                CALC: begin
                    acc_q <= acc_nxt_c;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (last_iter_c) Result <= res_c;
                end
                default: ;
            endcase
        end
    end

    assign Done     = done_q;
    assign RegWrite = done_q;

endmodule
